// File: rtl/sail_hex_bits_stream_if.sv
// Character-in / result-out stream bundle for the hex bitvector literal parser.
// The master side produces characters and consumes results; the slave side is the parser.
interface sail_hex_bits_stream_if #(
    parameter int WIDTH = 64
);
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       in_char;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic             out_ok;
    logic [WIDTH-1:0] out_value;

    modport master (
        output in_valid, in_char, in_last, out_ready,
        input  in_ready, out_valid, out_ok, out_value
    );

    modport slave (
        input  in_valid, in_char, in_last, out_ready,
        output in_ready, out_valid, out_ok, out_value
    );
endinterface

// File: rtl/sail_hex_bits_stream.sv
// Streaming parser for "0x<hex digits>" literals into a WIDTH-bit bitvector.
// One character per beat; the result appears one cycle after the in_last beat and is held until taken.
module sail_hex_bits_stream #(
    parameter int WIDTH = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    sail_hex_bits_stream_if.slave  bus
);
    // Wide enough to hold WIDTH+4 without wrapping, so an overflowing digit is always visible.
    localparam int SW = $clog2(WIDTH + 5) + 1;
    localparam logic [SW-1:0] SIG_LIMIT = SW'(WIDTH);
    localparam logic [SW-1:0] SIG_SAT   = SW'(WIDTH + 1);

    typedef enum logic [2:0] {
        P0,
        P1,
        FIRST,
        DIG,
        ERR,
        OUT
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_nx;
    logic [WIDTH+3:0] acc_shift;
    logic [SW-1:0]    sig;
    logic [SW-1:0]    sig_nx;
    logic [SW-1:0]    sig_cand;
    logic             overflow;
    logic             overflow_nx;
    logic             ok_q;
    logic             ok_nx;

    logic             in_ready_int;
    logic             beat;
    logic             is_hex;
    logic [3:0]       digit;
    logic             digit_ovf;

    assign in_ready_int  = (state != OUT);
    assign beat          = bus.in_valid && in_ready_int;
    assign acc_shift     = {acc, digit};

    assign bus.in_ready  = in_ready_int;
    assign bus.out_valid = (state == OUT);
    assign bus.out_ok    = (state == OUT) && ok_q;
    assign bus.out_value = ((state == OUT) && ok_q) ? acc : '0;

    always_comb begin
        is_hex = 1'b0;
        digit  = 4'd0;
        if (bus.in_char >= 8'h30 && bus.in_char <= 8'h39) begin
            is_hex = 1'b1;
            digit  = bus.in_char[3:0];
        end else if ((bus.in_char >= 8'h41 && bus.in_char <= 8'h46) ||
                     (bus.in_char >= 8'h61 && bus.in_char <= 8'h66)) begin
            is_hex = 1'b1;
            digit  = bus.in_char[3:0] + 4'd9;
        end
    end

    // Leading zeros leave sig at 0; the first nonzero digit contributes its own bit length.
    always_comb begin
        sig_cand = sig;
        if (sig == '0) begin
            case (digit)
                4'd0:                      sig_cand = SW'(0);
                4'd1:                      sig_cand = SW'(1);
                4'd2, 4'd3:                sig_cand = SW'(2);
                4'd4, 4'd5, 4'd6, 4'd7:    sig_cand = SW'(3);
                default:                   sig_cand = SW'(4);
            endcase
        end else begin
            sig_cand = sig + SW'(4);
        end
        digit_ovf = (sig_cand > SIG_LIMIT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= P0;
            acc      <= '0;
            sig      <= '0;
            overflow <= 1'b0;
            ok_q     <= 1'b0;
        end else begin
            state    <= state_nx;
            acc      <= acc_nx;
            sig      <= sig_nx;
            overflow <= overflow_nx;
            ok_q     <= ok_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        acc_nx      = acc;
        sig_nx      = sig;
        overflow_nx = overflow;
        ok_nx       = ok_q;

        case (state)
            P0: begin
                if (beat) begin
                    ok_nx = 1'b0;
                    if (bus.in_last)
                        state_nx = OUT;
                    else if (bus.in_char == 8'h30)
                        state_nx = P1;
                    else
                        state_nx = ERR;
                end
            end

            P1: begin
                if (beat) begin
                    ok_nx = 1'b0;
                    if (bus.in_last)
                        state_nx = OUT;
                    else if (bus.in_char == 8'h78)
                        state_nx = FIRST;
                    else
                        state_nx = ERR;
                end
            end

            FIRST, DIG: begin
                if (beat) begin
                    if (is_hex && !digit_ovf && !overflow) begin
                        acc_nx   = acc_shift[WIDTH-1:0];
                        sig_nx   = sig_cand;
                        ok_nx    = bus.in_last;
                        state_nx = bus.in_last ? OUT : DIG;
                    end else begin
                        if (is_hex) begin
                            overflow_nx = 1'b1;
                            sig_nx      = SIG_SAT;
                        end
                        ok_nx    = 1'b0;
                        state_nx = bus.in_last ? OUT : ERR;
                    end
                end
            end

            ERR: begin
                if (beat && bus.in_last) begin
                    ok_nx    = 1'b0;
                    state_nx = OUT;
                end
            end

            OUT: begin
                if (bus.out_ready) begin
                    state_nx    = P0;
                    acc_nx      = '0;
                    sig_nx      = '0;
                    overflow_nx = 1'b0;
                    ok_nx       = 1'b0;
                end
            end

            default: begin
                state_nx = P0;
            end
        endcase
    end
endmodule

// File: tb/tb_sail_hex_bits_stream.sv
// Scoreboard bench: two parsers (WIDTH 8 and 7) share one character stream; a monitor checks each result
// against a plain-arithmetic model of the literal rules.
module tb_sail_hex_bits_stream;
    typedef byte unsigned chq_t[$];
    typedef struct {
        int          id;
        bit          ok;
        logic [63:0] value;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic [7:0] in_char;
    logic       in_last;
    logic       out_ready;

    int   n_checks = 0;
    int   n_pass   = 0;
    int   str_id   = 0;
    exp_t q_a[$];
    exp_t q_b[$];

    always #5 clk = ~clk;

    sail_hex_bits_stream_if #(.WIDTH(8)) bus_a ();
    sail_hex_bits_stream_if #(.WIDTH(7)) bus_b ();

    assign bus_a.in_valid  = in_valid;
    assign bus_a.in_char   = in_char;
    assign bus_a.in_last   = in_last;
    assign bus_a.out_ready = out_ready;
    assign bus_b.in_valid  = in_valid;
    assign bus_b.in_char   = in_char;
    assign bus_b.in_last   = in_last;
    assign bus_b.out_ready = out_ready;

    sail_hex_bits_stream #(.WIDTH(8)) dut_a (.clk(clk), .reset(reset), .bus(bus_a.slave));
    sail_hex_bits_stream #(.WIDTH(7)) dut_b (.clk(clk), .reset(reset), .bus(bus_b.slave));

    task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
    endtask

    function automatic int hex_val(input byte unsigned c);
        if (c >= "0" && c <= "9") return int'(c) - 48;
        if (c >= "a" && c <= "f") return int'(c) - 87;
        if (c >= "A" && c <= "F") return int'(c) - 55;
        return -1;
    endfunction

    // A literal is good when it reads "0x" then one or more hex digits whose numeric value fits in w bits.
    function automatic void ref_model(input chq_t s, input int w, output bit ok, output logic [63:0] val);
        longint unsigned v = 0;
        bit good;
        good = (s.size() >= 3) && (s[0] == 8'h30) && (s[1] == 8'h78);
        for (int i = 2; i < s.size(); i++) begin
            if (!good) break;
            if (hex_val(s[i]) < 0) good = 1'b0;
            else begin
                v = v * 16 + longint'(hex_val(s[i]));
                if (v >= (64'd1 << w)) good = 1'b0;
            end
        end
        ok  = good;
        val = good ? v : 64'd0;
    endfunction

    function automatic chq_t to_q(input string s);
        chq_t q;
        for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
        return q;
    endfunction

    function automatic chq_t rand_str();
        chq_t  q;
        string hexs = "0123456789abcdefABCDEF";
        string bad  = "gGxX z/:@!";
        int    len  = $urandom_range(1, 8);
        int    r;
        for (int i = 0; i < len; i++) begin
            r = $urandom_range(0, 19);
            if (i == 0)      q.push_back((r != 0) ? 8'h30 : bad[$urandom_range(0, 9)]);
            else if (i == 1) q.push_back((r != 0) ? 8'h78 : bad[$urandom_range(0, 9)]);
            else if (r == 0) q.push_back(bad[$urandom_range(0, 9)]);
            else if (r < 8)  q.push_back(8'h30);
            else             q.push_back(hexs[$urandom_range(0, 21)]);
        end
        return q;
    endfunction

    // Results are compared at the negedge before the handshake edge, so both sides are stable.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && out_ready && bus_a.out_valid) begin
            check_output("a result pending", 64'(q_a.size() > 0), 64'd1);
            if (q_a.size() > 0) begin
                e = q_a.pop_front();
                check_output($sformatf("a str%0d ok", e.id), 64'(bus_a.out_ok), 64'(e.ok));
                check_output($sformatf("a str%0d value", e.id), 64'(bus_a.out_value), e.value);
            end
        end
        if (!reset && out_ready && bus_b.out_valid) begin
            check_output("b result pending", 64'(q_b.size() > 0), 64'd1);
            if (q_b.size() > 0) begin
                e = q_b.pop_front();
                check_output($sformatf("b str%0d ok", e.id), 64'(bus_b.out_ok), 64'(e.ok));
                check_output($sformatf("b str%0d value", e.id), 64'(bus_b.out_value), e.value);
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!bus_a.in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check_output("in_ready wait", 64'(bus_a.in_ready && bus_b.in_ready), 64'd1);
    endtask

    task automatic send_beats(input chq_t cq, input bit with_last);
        bit lb;
        for (int i = 0; i < cq.size(); i++) begin
            if ($urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                in_char  = 8'($urandom);
                in_last  = 1'($urandom);
                @(posedge clk); #1;
            end
            wait_ready();
            lb       = with_last && (i == cq.size() - 1);
            in_valid = 1'b1;
            in_char  = cq[i];
            in_last  = lb;
            @(posedge clk); #1;
            in_valid = 1'b0;
            in_last  = 1'b0;
            check_output(lb ? "latency out_valid" : "early out_valid",
                         64'({bus_a.out_valid, bus_b.out_valid}), lb ? 64'd3 : 64'd0);
        end
    endtask

    task automatic apply_stimulus(input chq_t cq, input int hold);
        exp_t ea;
        exp_t eb;
        str_id++;
        ea.id = str_id;
        eb.id = str_id;
        ref_model(cq, 8, ea.ok, ea.value);
        ref_model(cq, 7, eb.ok, eb.value);
        q_a.push_back(ea);
        q_b.push_back(eb);
        send_beats(cq, 1'b1);
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            check_output("hold valid/ready", 64'({bus_a.out_valid, bus_a.in_ready, bus_b.out_valid, bus_b.in_ready}), 64'b1010);
            check_output("hold a ok", 64'(bus_a.out_ok), 64'(ea.ok));
            check_output("hold a value", 64'(bus_a.out_value), ea.value);
            check_output("hold b ok", 64'(bus_b.out_ok), 64'(eb.ok));
            check_output("hold b value", 64'(bus_b.out_value), eb.value);
        end
        check_output("in_ready low in OUT", 64'({bus_a.in_ready, bus_b.in_ready}), 64'd0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check_output("after take", 64'({bus_a.out_valid, bus_a.in_ready, bus_b.out_valid, bus_b.in_ready}), 64'b0101);
        check_output("queues drained", 64'(q_a.size() + q_b.size()), 64'd0);
    endtask

    task automatic check_idle_outputs(input string name);
        check_output({name, " a"}, 64'({bus_a.out_valid, bus_a.out_ok, bus_a.in_ready}), 64'b001);
        check_output({name, " b"}, 64'({bus_b.out_valid, bus_b.out_ok, bus_b.in_ready}), 64'b001);
        check_output({name, " values"}, 64'(bus_a.out_value) | 64'(bus_b.out_value), 64'd0);
    endtask

    initial begin
        string directed[$];
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_char   = 8'h00;
        in_last   = 1'b0;
        out_ready = 1'b0;
        #1;
        check_idle_outputs("reset state");
        #12 reset = 1'b0;
        @(posedge clk); #1;

        directed = '{"0x0F", "0x00001ff", "0x000ff", "0x7f", "0x80", "0x000",
                     "0x", "0xg12", "0X1", "0", "0x1", "0xFe", "0x100", "1x5"};
        foreach (directed[i]) apply_stimulus(to_q(directed[i]), (i == 0) ? 3 : $urandom_range(0, 2));

        // A pending result is thrown away by reset between clock edges.
        send_beats(to_q("0x5"), 1'b1);
        #3 reset = 1'b1;
        #1;
        check_idle_outputs("reset in OUT");
        q_a.delete();
        q_b.delete();
        #2 reset = 1'b0;
        @(posedge clk); #1;

        send_beats(to_q("0x1"), 1'b0);
        #3 reset = 1'b1;
        #1;
        check_idle_outputs("reset mid string");
        #2 reset = 1'b0;
        @(posedge clk); #1;
        apply_stimulus(to_q("0x2"), 1);

        for (int n = 0; n < 80; n++) apply_stimulus(rand_str(), $urandom_range(0, 3));

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/sail_hex_bits_stream.md
SAIL_HEX_BITS_STREAM -- requirements
Module: sail_hex_bits_stream

Interface
REQ-001 SHALL have parameter WIDTH, default 64, which is the target bitvector width N (legal range 1..1024).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port in_valid, input, 1 bit: in_char is presented.
REQ-005 SHALL have port in_ready, output, 1 bit: block accepts a character this cycle.
REQ-006 SHALL have port in_char, input, 8 bits: ASCII character of the string.
REQ-007 SHALL have port in_last, input, 1 bit: in_char is the final character of the string.
REQ-008 SHALL have port out_valid, output, 1 bit: a result is presented.
REQ-009 SHALL have port out_ready, input, 1 bit: consumer takes the result.
REQ-010 SHALL have port out_ok, output, 1 bit: the string is a valid hex literal for WIDTH bits.
REQ-011 SHALL have port out_value, output, WIDTH bits: the parsed value, zero-extended.

Function
REQ-012 SHALL accept a character only when in_valid and in_ready are both high in the same cycle (a beat); no other character is consumed.
REQ-013 SHALL implement states P0, P1, FIRST, DIG, ERR and OUT; in_ready SHALL be 1 in every state except OUT.
REQ-014 P0: a beat with '0' (0x30) SHALL go to P1; any other character SHALL go to ERR.
REQ-015 P1: a beat with lowercase 'x' (0x78) SHALL go to FIRST; any other character, including 'X', SHALL go to ERR.
REQ-016 FIRST/DIG: a beat with a hex digit (0-9, A-F, a-f) SHALL go to DIG and update the accumulator; a non-hex character SHALL go to ERR.
REQ-017 Accumulator SHALL compute acc = (acc << 4) | digit, truncated to WIDTH bits.
REQ-018 Significant-bit counter sig SHALL track the bit width of the parsed value as follows:
- stays 0 while acc==0 and digit==0 (leading zeros ignored);
- on the first nonzero digit, set to 1 for digit 1, 2 for 2-3, 3 for 4-7, 4 for 8-F;
- thereafter increase by 4 per digit.
REQ-019 When sig would exceed WIDTH, SHALL set a sticky overflow error and go to ERR; sig SHALL saturate, with no wrap for any string length.
REQ-020 ERR SHALL consume beats without inspecting them until a beat with in_last.
REQ-021 A beat with in_last in any state SHALL go to OUT in the next cycle:
- out_ok=1 only if the beat was in FIRST/DIG, was a valid digit, and did not overflow;
- a last beat in P0 or P1 (length < 3) SHALL give out_ok=0.
REQ-022 Result latency SHALL be exactly 1 cycle: out_valid rises in the cycle after the in_last beat.
REQ-023 In OUT, out_valid=1, and out_ok and out_value SHALL be held stable until out_ready is high; out_value SHALL be 0 whenever out_ok=0.
REQ-024 In a cycle with out_valid and out_ready both high, SHALL go to P0 and clear acc, sig and overflow; in_ready SHALL rise in the next cycle, not in the same cycle.
REQ-025 out_ready while out_valid=0 SHALL be ignored; in_char and in_last SHALL be ignored when there is no beat.
REQ-026 Outside OUT, out_valid=0, out_ok=0 and out_value=0.

Reset
REQ-027 While reset is high, SHALL immediately force state P0, acc=0, sig=0, overflow=0, out_valid=0, out_ok=0, out_value=0 and in_ready=1, independent of clk.
REQ-028 Reset mid-string or mid-OUT SHALL discard the partial string or pending result; the first beat after reset deasserts SHALL be treated as character 0 of a new string.

Verification
REQ-029 WIDTH=8, stream "0x0F" with in_last on 'F' -> next cycle out_valid=1, out_ok=1, out_value=0x0F.
REQ-030 WIDTH=8, "0x00001ff" -> out_ok=0, out_value=0 (9 significant bits); "0x000ff" -> out_ok=1, out_value=0xFF.
REQ-031 WIDTH=7, "0x7f" -> ok=1, value 0x7F; "0x80" -> ok=0; "0x000" -> ok=1, value 0.
REQ-032 "0x" with in_last on 'x' -> ok=0; "0xg12" -> ok=0, with the result only after '2' (the last beat); "0X1" -> ok=0.
REQ-033 Hold out_ready=0 for 3 cycles after a result -> out_valid, out_ok and out_value stable and in_ready=0 throughout; out_ready=1 -> out_valid=0 and in_ready=1 on the next cycle.
REQ-034 Assert reset after beats "0x1" -> all outputs 0 and in_ready=1 without a clock edge; then "0x2" -> ok=1, value 0x2.
